// File: rtl/monpro_arbiter_pkg.sv
// Shared constants and types for the MonPro arbiter.
//   DATA_WIDTH / TOTAL_ADDR : operand word width and words per operand
//   WRITEOUT                : engine state code that marks result streaming
//   arb_state_e             : arbiter FSM states
package monpro_arbiter_pkg;

  localparam int unsigned DATA_WIDTH = 128;
  localparam int unsigned TOTAL_ADDR = 32;
  localparam int unsigned ADDR_W     = $clog2(TOTAL_ADDR);
  // LOAD counts 0 .. 2*TOTAL_ADDR+1
  localparam int unsigned CNT_W      = $clog2(2 * TOTAL_ADDR + 2);
  localparam int unsigned WD_W       = 16;

  localparam logic [4:0] WRITEOUT = 5'd12;

  typedef enum logic [2:0] {
    ArbIdle,
    ArbStart,
    ArbLoad,
    ArbWait,
    ArbDrain
  } arb_state_e;

endpackage

// File: rtl/monpro_arbiter_if.sv
// Bus bundle between the arbiter, its two requesters and the MonPro engine.
//   slave  : arbiter side (samples req/read data/engine, drives everything else)
//   master : environment side (requesters, operand memories, engine)
interface monpro_arbiter_if;
  import monpro_arbiter_pkg::*;

  logic [1:0]            req;
  logic [1:0]            gnt;
  logic                  rd_en;
  logic                  rd_sel;
  logic [ADDR_W-1:0]     rd_addr;
  logic [DATA_WIDTH-1:0] rd_data0;
  logic [DATA_WIDTH-1:0] rd_data1;
  logic                  mp_start;
  logic [DATA_WIDTH-1:0] mp_inp;
  logic [4:0]            mp_state;
  logic [DATA_WIDTH-1:0] mp_outp;
  logic [1:0]            rsp_valid;
  logic [ADDR_W-1:0]     rsp_idx;
  logic [DATA_WIDTH-1:0] rsp_data;
  logic                  rsp_last;
  logic                  err;
  logic                  busy;

  modport slave (
    input  req, rd_data0, rd_data1, mp_state, mp_outp,
    output gnt, rd_en, rd_sel, rd_addr, mp_start, mp_inp,
           rsp_valid, rsp_idx, rsp_data, rsp_last, err, busy
  );

  modport master (
    output req, rd_data0, rd_data1, mp_state, mp_outp,
    input  gnt, rd_en, rd_sel, rd_addr, mp_start, mp_inp,
           rsp_valid, rsp_idx, rsp_data, rsp_last, err, busy
  );

endinterface

// File: rtl/monpro_arbiter_rr_pick2.sv
// Combinational round-robin selector for two requesters.
//   req_i        : request levels
//   last_owner_i : requester served last; loses a tie
//   pick_o       : one-hot selection (zero when nobody requests)
//   valid_o      : at least one request present
module monpro_arbiter_rr_pick2 (
  input  logic [1:0] req_i,
  input  logic       last_owner_i,
  output logic [1:0] pick_o,
  output logic       valid_o
);

  always_comb begin
    pick_o = req_i;
    if (req_i == 2'b11) begin
      pick_o = last_owner_i ? 2'b01 : 2'b10;
    end
  end

  assign valid_o = |req_i;

endmodule

// File: rtl/monpro_arbiter.sv
// Shares one MonPro engine between two requesters, one full Montgomery
// product per grant: read A/B from the owner, stream them to the engine,
// wait for WRITEOUT (with watchdog), return the result words, release.
//   clk, reset : clock and asynchronous active-high reset
//   bus        : requester handshake, operand read port, engine port,
//                result stream, err pulse and busy flag
module monpro_arbiter
  import monpro_arbiter_pkg::*;
#(
  parameter int unsigned TIMEOUT = 65535
) (
  input logic             clk,
  input logic             reset,
  monpro_arbiter_if.slave bus
);

  localparam logic [CNT_W-1:0] GapCnt    = CNT_W'(TOTAL_ADDR);
  localparam logic [CNT_W-1:0] LoadLast  = CNT_W'(2 * TOTAL_ADDR + 1);
  localparam logic [CNT_W-1:0] DrainLast = CNT_W'(TOTAL_ADDR - 1);
  localparam logic [WD_W-1:0]  WdLimit   = WD_W'(TIMEOUT);

  arb_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WD_W-1:0]  wd_q, wd_d, wd_inc;
  logic [1:0]       gnt_q, gnt_d;
  logic             owner_q, owner_d;
  logic             last_owner_q, last_owner_d;
  logic             mp_start_q, mp_start_d;
  logic             rd_vld_q, rd_vld_d;
  logic             err_q, err_d;
  logic             rel;

  logic [1:0]            pick;
  logic                  pick_valid;
  logic                  rd_en, rd_sel;
  logic [ADDR_W-1:0]     rd_addr;
  logic [1:0]            rsp_valid;
  logic [ADDR_W-1:0]     rsp_idx;
  logic [DATA_WIDTH-1:0] rsp_data;
  logic                  rsp_last;

  monpro_arbiter_rr_pick2 u_pick (
    .req_i       (bus.req),
    .last_owner_i(last_owner_q),
    .pick_o      (pick),
    .valid_o     (pick_valid)
  );

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    wd_d         = wd_q;
    gnt_d        = gnt_q;
    owner_d      = owner_q;
    last_owner_d = last_owner_q;
    mp_start_d   = mp_start_q;
    rd_vld_d     = 1'b0;
    err_d        = 1'b0;
    rel          = 1'b0;
    rd_en        = 1'b0;
    rd_sel       = 1'b0;
    rd_addr      = '0;
    rsp_valid    = '0;
    rsp_idx      = '0;
    rsp_data     = '0;
    rsp_last     = 1'b0;
    wd_inc       = (wd_q == '1) ? wd_q : wd_q + WD_W'(1);

    unique case (state_q)
      ArbIdle: begin
        if (pick_valid) begin
          gnt_d   = pick;
          owner_d = pick[1];
          state_d = ArbStart;
        end
      end
      ArbStart: begin
        mp_start_d = 1'b1;
        cnt_d      = '0;
        state_d    = ArbLoad;
      end
      ArbLoad: begin
        // A words, one gap slot at cnt == TOTAL_ADDR, then B words
        if (cnt_q < GapCnt) begin
          rd_en   = 1'b1;
          rd_addr = cnt_q[ADDR_W-1:0];
        end else if (cnt_q > GapCnt && cnt_q != LoadLast) begin
          rd_en   = 1'b1;
          rd_sel  = 1'b1;
          rd_addr = ADDR_W'(cnt_q - GapCnt - CNT_W'(1));
        end
        rd_vld_d = rd_en;
        if (cnt_q == LoadLast) begin
          wd_d    = '0;
          state_d = ArbWait;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ArbWait: begin
        if (bus.mp_state == WRITEOUT) begin
          cnt_d   = '0;
          state_d = ArbDrain;
        end else begin
          wd_d = wd_inc;
          if (wd_inc == WdLimit) begin
            err_d = 1'b1;
            rel   = 1'b1;
          end
        end
      end
      ArbDrain: begin
        rsp_valid[owner_q] = 1'b1;
        rsp_data           = bus.mp_outp;
        rsp_idx            = cnt_q[ADDR_W-1:0];
        if (cnt_q == DrainLast) begin
          rsp_last = 1'b1;
          rel      = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: state_d = ArbIdle;
    endcase

    if (rel) begin
      gnt_d        = '0;
      mp_start_d   = 1'b0;
      rd_vld_d     = 1'b0;
      last_owner_d = owner_q;
      state_d      = ArbIdle;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= ArbIdle;
      cnt_q        <= '0;
      wd_q         <= '0;
      gnt_q        <= '0;
      owner_q      <= 1'b0;
      last_owner_q <= 1'b1;
      mp_start_q   <= 1'b0;
      rd_vld_q     <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      wd_q         <= wd_d;
      gnt_q        <= gnt_d;
      owner_q      <= owner_d;
      last_owner_q <= last_owner_d;
      mp_start_q   <= mp_start_d;
      rd_vld_q     <= rd_vld_d;
      err_q        <= err_d;
    end
  end

  assign bus.gnt       = gnt_q;
  assign bus.rd_en     = rd_en;
  assign bus.rd_sel    = rd_sel;
  assign bus.rd_addr   = rd_addr;
  assign bus.mp_start  = mp_start_q;
  // Read data arrives the cycle after rd_en; the registered strobe gates the
  // owner's word straight onto the engine input, zero otherwise.
  assign bus.mp_inp    = rd_vld_q ? (owner_q ? bus.rd_data1 : bus.rd_data0) : '0;
  assign bus.rsp_valid = rsp_valid;
  assign bus.rsp_idx   = rsp_idx;
  assign bus.rsp_data  = rsp_data;
  assign bus.rsp_last  = rsp_last;
  assign bus.err       = err_q;
  assign bus.busy      = (state_q != ArbIdle);

endmodule

// File: tb/tb_monpro_arbiter.sv
// Directed-plus-random bench for monpro_arbiter: operand memories and a
// stub engine, expected feed/result streams built from the transaction rules.
module tb_monpro_arbiter;
  import monpro_arbiter_pkg::*;

  localparam int T  = TOTAL_ADDR;
  localparam int DW = DATA_WIDTH;
  localparam int TO = 100;

  typedef logic [DW-1:0] word_t;

  logic  clk = 1'b0;
  logic  reset;
  int    vectors = 0;
  int    miscompares = 0;
  int    model_last;
  word_t mem_a [2][T];
  word_t mem_b [2][T];
  word_t res   [T];

  monpro_arbiter_if bus ();

  monpro_arbiter #(.TIMEOUT(TO)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  // Owner memories: synchronous read, data valid the cycle after rd_en.
  always @(posedge clk) begin
    if (bus.rd_en) begin
      bus.rd_data0 <= bus.rd_sel ? mem_b[0][bus.rd_addr] : mem_a[0][bus.rd_addr];
      bus.rd_data1 <= bus.rd_sel ? mem_b[1][bus.rd_addr] : mem_a[1][bus.rd_addr];
    end
  end

  task automatic chk(input string tag, input word_t obs, input word_t exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: got %0h, want %0h", tag, obs, exp);
    end
  endtask

  function automatic word_t rand_word();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  task automatic fill(input int r, input bit pattern);
    for (int i = 0; i < T; i++) begin
      mem_a[r][i] = pattern ? word_t'(i + 1) : rand_word();
      mem_b[r][i] = pattern ? word_t'(2 * i) : rand_word();
    end
  endtask

  // Round-robin rule: a tie goes to whoever was not served last.
  function automatic int model_pick(input logic [1:0] r);
    if (r == 2'b11) return (model_last == 1) ? 0 : 1;
    return r[1] ? 1 : 0;
  endfunction

  task automatic chk_zero(input string where);
    chk({where, "_ctl"}, DW'({bus.gnt, bus.rd_en, bus.rd_sel, bus.rd_addr, bus.mp_start,
                              bus.rsp_valid, bus.rsp_idx, bus.rsp_last, bus.err, bus.busy}), '0);
    chk({where, "_mp_inp"}, bus.mp_inp, '0);
    chk({where, "_rsp_data"}, bus.rsp_data, '0);
  endtask

  // Assert reset between clock edges, check outputs before any edge, release.
  task automatic hit_reset(input string where);
    #2 reset = 1'b1;
    #1 chk_zero(where);
    bus.mp_state = '0;
    bus.mp_outp  = '0;
    @(negedge clk);
    reset      = 1'b0;
    model_last = 1;
  endtask

  // Runs one transaction from the IDLE negedge at which req is presented.
  // Returns at the IDLE negedge after release (or right after a reset hit).
  task automatic do_txn(input int own, input int compute, input bit timeout,
                        input int drop_at, input int rst_wait, input int rst_drain);
    word_t      feed [$];
    logic [1:0] oh;
    bit         exp_en, exp_sel;
    logic [4:0] exp_addr;
    oh = (own == 1) ? 2'b10 : 2'b01;
    feed.push_back('0);
    for (int i = 0; i < T; i++) feed.push_back(mem_a[own][i]);
    feed.push_back('0);
    for (int i = 0; i < T; i++) feed.push_back(mem_b[own][i]);
    for (int j = 0; j < T; j++) res[j] = rand_word();

    @(negedge clk);
    chk("start_gnt_mpstart", DW'({bus.gnt, bus.mp_start, bus.busy}), DW'({oh, 2'b01}));

    for (int c = 0; c < 2 * T + 2; c++) begin
      @(negedge clk);
      exp_en   = (c < T) || (c > T && c <= 2 * T);
      exp_sel  = (c > T);
      exp_addr = 5'((c < T) ? c : c - T - 1);
      chk($sformatf("load%0d_gnt", c), DW'({bus.gnt, bus.mp_start}), DW'({oh, 1'b1}));
      chk($sformatf("load%0d_mp_inp", c), bus.mp_inp, feed[c]);
      chk($sformatf("load%0d_rd_en", c), DW'(bus.rd_en), DW'(exp_en));
      if (exp_en)
        chk($sformatf("load%0d_rd_addr", c), DW'({bus.rd_sel, bus.rd_addr}),
            DW'({exp_sel, exp_addr}));
      if (c == drop_at) bus.req = 2'b00;
    end

    if (timeout) begin
      for (int k = 0; k < TO; k++) begin
        @(negedge clk);
        chk($sformatf("wait%0d", k), DW'({bus.err, bus.rsp_valid, bus.busy}), DW'(4'b0001));
      end
      @(negedge clk);
      chk("timeout_err", DW'({bus.err, bus.gnt, bus.busy, bus.rsp_valid}), DW'(6'b100000));
      model_last = own;
      return;
    end

    for (int k = 0; k < compute; k++) begin
      @(negedge clk);
      chk("wait_state", DW'({bus.err, bus.rsp_valid, bus.busy, bus.mp_inp == '0}),
          DW'(5'b00011));
      if (k == rst_wait) begin
        hit_reset("rst_wait");
        return;
      end
      if (k == compute - 1) begin
        bus.mp_state = WRITEOUT;
        bus.mp_outp  = res[0];
      end
    end

    for (int j = 0; j < T; j++) begin
      @(negedge clk);
      chk($sformatf("drain%0d_ctl", j), DW'({bus.rsp_valid, bus.rsp_idx, bus.rsp_last, bus.gnt}),
          DW'({oh, 5'(j), j == T - 1, oh}));
      chk($sformatf("drain%0d_data", j), bus.rsp_data, res[j]);
      if (j == rst_drain) begin
        hit_reset("rst_drain");
        return;
      end
      bus.mp_outp = (j < T - 1) ? res[j + 1] : '0;
    end
    bus.mp_state = '0;

    @(negedge clk);
    chk("idle_after", DW'({bus.gnt, bus.busy, bus.rsp_valid, bus.err, bus.mp_start}), '0);
    model_last = own;
  endtask

  initial begin
    int own;
    int drop;
    reset        = 1'b1;
    bus.req      = '0;
    bus.mp_state = '0;
    bus.mp_outp  = '0;
    model_last   = 1;
    fill(0, 1'b1);
    fill(1, 1'b0);

    @(negedge clk);
    chk_zero("reset");
    @(negedge clk);
    reset = 1'b0;

    // Single requester with patterned operands.
    bus.req = 2'b01;
    own = model_pick(bus.req);
    do_txn(own, 5, 1'b0, -1, -1, -1);
    bus.req = '0;
    @(negedge clk);
    chk("idle_hold", DW'({bus.gnt, bus.busy}), '0);

    // Ties from reset: 0, 1, 0 back-to-back.
    hit_reset("pre_tie");
    bus.req = 2'b11;
    repeat (3) begin
      fill(0, 1'b0);
      fill(1, 1'b0);
      own = model_pick(bus.req);
      do_txn(own, int'($urandom_range(1, 30)), 1'b0, -1, -1, -1);
    end
    bus.req = '0;
    @(negedge clk);

    // Request dropped during LOAD; transaction still completes.
    bus.req = 2'b10;
    own = model_pick(bus.req);
    do_txn(own, 12, 1'b0, 4, -1, -1);
    @(negedge clk);
    chk("drop_no_regrant", DW'({bus.gnt, bus.busy}), '0);

    // Engine never reaches WRITEOUT.
    bus.req = 2'b01;
    own = model_pick(bus.req);
    do_txn(own, 0, 1'b1, 0, -1, -1);
    @(negedge clk);
    chk("err_once", DW'({bus.err, bus.gnt, bus.busy, bus.rsp_valid}), '0);

    // Reset in WAIT, then in DRAIN word 10, then a clean transaction.
    bus.req = 2'b11;
    own = model_pick(bus.req);
    do_txn(own, 30, 1'b0, -1, 5, -1);
    own = model_pick(bus.req);
    do_txn(own, 20, 1'b0, -1, -1, 10);
    own = model_pick(bus.req);
    do_txn(own, 8, 1'b0, -1, -1, -1);
    bus.req = '0;
    @(negedge clk);

    // Random request patterns, operands, latencies and drops.
    for (int n = 0; n < 6; n++) begin
      fill(0, 1'b0);
      fill(1, 1'b0);
      drop = ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, 2 * T + 1)) : -1;
      bus.req = 2'($urandom_range(1, 3));
      own = model_pick(bus.req);
      do_txn(own, int'($urandom_range(1, 40)), 1'b0, drop, -1, -1);
      bus.req = '0;
      @(negedge clk);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/monpro_arbiter.md
# monpro_arbiter

Shares one MonPro (Montgomery product) engine between two requesters, for example two modular-exponentiation sequencers or an exponentiator plus a pre-computation unit. Each transaction is one complete MonPro operation:
- grant the requester;
- read operands A and B from the requester's word memories;
- stream them into the engine using its start/A/gap/B protocol;
- wait for the engine's WRITEOUT state;
- return the result words to the owner;
- release the engine.

Requesters are served round-robin at transaction granularity.

## Interface
- `DATA_WIDTH`, 128: word width.
- `TOTAL_ADDR`, 32: words per operand (4096 / 128).
- `TIMEOUT`, 65535: maximum number of cycles spent in WAIT before the transaction is aborted.

- `clk` in 1: single clock.
- `reset` in 1: asynchronous, active-high reset.
- `req` in 2: per-requester request level.
- `gnt` out 2: one-hot; held for the whole transaction.
- `rd_en` out 1: operand read strobe to the owner.
- `rd_sel` out 1: operand select, 0 = A, 1 = B.
- `rd_addr` out 5: operand word index, `$clog2(TOTAL_ADDR)` bits.
- `rd_data0`, `rd_data1` in DATA_WIDTH: owner's read data, valid exactly 1 cycle after `rd_en`.
- `mp_start` out 1: MonPro start.
- `mp_inp` out DATA_WIDTH: MonPro input word.
- `mp_state` in 5: MonPro state code.
- `mp_outp` in DATA_WIDTH: MonPro output word.
- `rsp_valid` out 2: per-requester result-word strobe.
- `rsp_idx` out 5: index of the current result word.
- `rsp_data` out DATA_WIDTH: result word.
- `rsp_last` out 1: high with the final result word.
- `err` out 1: one-cycle pulse when a transaction is aborted by timeout.
- `busy` out 1: high in every state except IDLE.

## Operation
The state machine has five states: IDLE, START, LOAD, WAIT, DRAIN.

- **IDLE**
  - If any `req` bit is high, select the owner.
  - When both are high, select the requester that is not `last_owner`; otherwise select the single requester.
  - Set `gnt[owner]` and go to START.
- **START** (1 cycle): `mp_start`=1, `cnt`=0, go to LOAD.
- **LOAD**
  - `cnt` runs 0 through 2·TOTAL_ADDR+1.
  - `cnt` in [0, TOTAL_ADDR−1]: `rd_en`=1, `rd_sel`=0, `rd_addr`=`cnt`.
  - `cnt`=TOTAL_ADDR: no read; this is the gap slot.
  - `cnt` in [TOTAL_ADDR+1, 2·TOTAL_ADDR]: `rd_en`=1, `rd_sel`=1, `rd_addr`=`cnt`−TOTAL_ADDR−1.
  - Every cycle, `mp_inp` is registered as: the owner's `rd_data` if `rd_en` was high in the previous cycle, else 0.
  - After `cnt`=2·TOTAL_ADDR+1, go to WAIT.
- **WAIT**
  - Watchdog counts up from 0.
  - On `mp_state`==WRITEOUT, go to DRAIN with `cnt`=0.
  - If the watchdog reaches TIMEOUT, pulse `err`, perform release, go to IDLE. No `rsp_valid` is emitted.
- **DRAIN**
  - Runs TOTAL_ADDR cycles: `rsp_valid[owner]`=1, `rsp_data`=`mp_outp`, `rsp_idx`=`cnt`.
  - `rsp_last`=1 when `cnt`=TOTAL_ADDR−1; then perform release and go to IDLE.
- **Release** (same clock edge): `gnt`=0, `mp_start`=0, `mp_inp`=0, `last_owner`=owner.

Rules:
- Deasserting `req` mid-transaction is ignored; the transaction always completes or times out.
- `req` is re-sampled only in IDLE.
- Counters are unsigned and never wrap inside a state. The watchdog is 16 bits, saturating.

## Timing
- **Reset** (asynchronous, any state):
  - State goes to IDLE.
  - Every output is 0: `gnt`, `rd_en`, `rd_sel`, `rd_addr`, `mp_start`, `mp_inp`, `rsp_*`, `err`, `busy`.
  - `last_owner`=1, so requester 0 wins the first tie.
  - Reset during DRAIN drops the remaining result words.
- **Grant latency:** `req` sampled high in IDLE at edge t gives `gnt` at t+1 and `mp_start` at t+2.
- **Engine feed:** `mp_inp` carries A[0..TOTAL_ADDR−1] on LOAD cycles 1..TOTAL_ADDR, 0 on cycle TOTAL_ADDR+1, and B[0..TOTAL_ADDR−1] on cycles TOTAL_ADDR+2..2·TOTAL_ADDR+1.
- **Result:** the first `rsp_valid` is the cycle after WRITEOUT is seen, i.e. DRAIN's first cycle.
- **Back-to-back:** `gnt` is low for exactly 1 cycle (IDLE) between transactions.
- **Fixed overhead:** a transaction takes 2·TOTAL_ADDR + TOTAL_ADDR + 4 cycles plus the engine's compute time.

## Structure
- Shared constants go in `_parameter.v`:
  - `DATA_WIDTH`, `TOTAL_ADDR`;
  - MonPro state code `WRITEOUT`;
  - new arbiter state codes `ARB_IDLE` through `ARB_DRAIN`.
- One sub-module, `rr_pick2`: combinational round-robin selector for two requesters. Inputs are `req[1:0]` and `last_owner`; outputs are a one-hot pick and `valid`.
- Everything else lives in one sequential block in `monpro_arbiter`.

## Test plan
- **Single requester:** `req`=01 with A=i+1 and B=2i.
  - `mp_start` rises 2 cycles after `req`.
  - `mp_inp` shows 1..32, then a 0 gap, then 0,2,..,62.
  - After the stubbed WRITEOUT, `rsp_valid`=01 for 32 cycles with `rsp_data`=`mp_outp`, and `rsp_last` on index 31.
- **Tie:** `req`=11 from reset. Requester 0 is served, then requester 1, with `gnt` low for 1 cycle between. A further tie grants 0 again.
- **Requester drops `req` during LOAD:** the transaction completes and all 32 `rsp_valid` pulses still arrive.
- **Timeout:** with TIMEOUT=100 and a stub that never reports WRITEOUT, `err` pulses once at WAIT cycle 100, no `rsp_valid` occurs, and `gnt` clears.
- **Reset in WAIT and again in DRAIN word 10:** all outputs are 0 immediately and asynchronously; the next `req`=11 grants requester 0.
